// File: rtl/io_rf_write_bridge.sv
// Packs bytes from an IO source into a DATA_W word and writes it to register 31
// when the core write-back port is idle. Optional parity: IO_BRIDGE_PARITY_EN.
`timescale 1ns/1ps
module io_rf_write_bridge #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
`ifdef IO_BRIDGE_PARITY_EN
    input  logic              in_parity,
    output logic              parity_err,
`endif
    output logic              in_ready,
    input  logic              in_abort,
    input  logic              rf_we_busy,
    output logic              io_we,
    output logic [DATA_W-1:0] data_io,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              pending
);
    localparam int unsigned NUM_BYTES = DATA_W / 8;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PENDING = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_byte_idx;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_data_io;
    logic [CNT_W-1:0]    r_word_cnt;
    logic                r_in_ready;
    logic                r_io_we;
    logic                r_pending;

    state_t              w_state_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_par_ok;

`ifdef IO_BRIDGE_PARITY_EN
    logic r_parity_err;
    logic w_perr_set;

    // Even parity: in_parity must equal the XOR of the byte bits.
    assign w_par_ok   = ((^in_byte) == in_parity);
    assign w_perr_set = (r_state == ST_COLLECT) && in_valid && !in_abort && !w_par_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (in_abort) begin
            r_parity_err <= 1'b0;
        end else if (w_perr_set) begin
            r_parity_err <= 1'b1;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign w_par_ok = 1'b1;
`endif

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_byte_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data_io;
        w_cnt_nxt   = r_word_cnt;
        unique case (r_state)
            ST_COLLECT: begin
                if (in_abort) begin
                    w_idx_nxt   = '0;
                    w_shift_nxt = '0;
                end else if (in_valid && w_par_ok) begin
                    w_shift_nxt[{r_byte_idx, 3'b000} +: 8] = in_byte;
                    if (r_byte_idx == LAST_IDX) begin
                        w_state_nxt = ST_PENDING;
                    end else begin
                        w_idx_nxt = r_byte_idx + IDX_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (in_abort) begin
                    w_state_nxt = ST_COLLECT;
                    w_idx_nxt   = '0;
                    w_shift_nxt = '0;
                end else if (!rf_we_busy) begin
                    w_state_nxt = ST_WRITE;
                    w_data_nxt  = r_shift;
                end
            end
            ST_WRITE: begin
                // Committed: abort and busy are not looked at here.
                w_state_nxt = ST_COLLECT;
                w_idx_nxt   = '0;
                w_shift_nxt = '0;
                w_cnt_nxt   = r_word_cnt + CNT_W'(1);
            end
            default: begin
                w_state_nxt = ST_COLLECT;
                w_idx_nxt   = '0;
                w_shift_nxt = '0;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_COLLECT;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_data_io  <= '0;
            r_word_cnt <= '0;
            r_in_ready <= 1'b1;
            r_io_we    <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_data_io  <= w_data_nxt;
            r_word_cnt <= w_cnt_nxt;
            r_in_ready <= (w_state_nxt == ST_COLLECT);
            r_io_we    <= (w_state_nxt == ST_WRITE);
            r_pending  <= (w_state_nxt == ST_PENDING);
        end
    end

    assign in_ready = r_in_ready;
    assign io_we    = r_io_we;
    assign data_io  = r_data_io;
    assign word_cnt = r_word_cnt;
    assign pending  = r_pending;

endmodule

// File: tb/tb_io_rf_write_bridge.sv
// Self-checking bench for io_rf_write_bridge: directed cases plus random words
// compared against a byte-queue reference model.
`timescale 1ns/1ps
module tb_io_rf_write_bridge;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        in_abort;
    logic        rf_we_busy;
    logic        io_we;
    logic [31:0] data_io;
    logic [7:0]  word_cnt;
    logic        pending;
`ifdef IO_BRIDGE_PARITY_EN
    logic        in_parity;
    logic        parity_err;
`endif

    int          checks;
    int          errors;
    int          cyc;
    int          we_seen;
    int          consec;
    int          we_cyc_now;
    int          we_cyc_prev;
    int          exp_cnt;
    logic        prev_we;
    logic [7:0]  q[$];
    logic [31:0] exp_word;
    int          we_before;

    io_rf_write_bridge #(.DATA_W(32), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
`ifdef IO_BRIDGE_PARITY_EN
        .in_parity  (in_parity),
        .parity_err (parity_err),
`endif
        .in_ready   (in_ready),
        .in_abort   (in_abort),
        .rf_we_busy (rf_we_busy),
        .io_we      (io_we),
        .data_io    (data_io),
        .word_cnt   (word_cnt),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (io_we === 1'b1) begin
            we_seen++;
            we_cyc_prev = we_cyc_now;
            we_cyc_now  = cyc;
            if (prev_we === 1'b1) consec++;
        end
        prev_we = io_we;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
`ifdef IO_BRIDGE_PARITY_EN
        in_parity = ^b;
`endif
        chk("in_ready_collect", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                chk("in_ready_gap", 32'(in_ready), 32'(1));
                step();
            end
            send_byte(w[8*k +: 8]);
            q.push_back(w[8*k +: 8]);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w = w | (32'(q[k]) << (8 * k));
        return w;
    endfunction

    // Called in the first PENDING cycle after the last byte was accepted.
    task automatic expect_write(input logic [31:0] exp_w, input int busy,
                                input bit abort_in_write, input bit hold_valid);
        if (hold_valid) begin
            in_valid = 1'b1;
            in_byte  = 8'hEE;
        end
        for (int i = 0; i < busy; i++) begin
            rf_we_busy = 1'b1;
            chk("pend_busy_pending", 32'(pending), 32'(1));
            chk("pend_busy_ready", 32'(in_ready), 32'(0));
            chk("pend_busy_we", 32'(io_we), 32'(0));
            step();
        end
        rf_we_busy = 1'b0;
        chk("pend_pending", 32'(pending), 32'(1));
        chk("pend_ready", 32'(in_ready), 32'(0));
        chk("pend_we", 32'(io_we), 32'(0));
        step();
        chk("write_we", 32'(io_we), 32'(1));
        chk("write_data", data_io, exp_w);
        chk("write_ready", 32'(in_ready), 32'(0));
        chk("write_pending", 32'(pending), 32'(0));
        if (abort_in_write) in_abort = 1'b1;
        rf_we_busy = 1'($urandom_range(1, 0));
        step();
        in_abort   = 1'b0;
        rf_we_busy = 1'b0;
        in_valid   = 1'b0;
        exp_cnt    = (exp_cnt + 1) % 256;
        chk("after_we", 32'(io_we), 32'(0));
        chk("after_ready", 32'(in_ready), 32'(1));
        chk("after_cnt", 32'(word_cnt), 32'(exp_cnt));
        chk("after_data_hold", data_io, exp_w);
        q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_abort = 1'b0;
        rf_we_busy = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = 0;
        q.delete();
        step();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; we_seen = 0; consec = 0;
        we_cyc_now = 0; we_cyc_prev = 0; exp_cnt = 0; prev_we = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        in_abort = 1'b0; rf_we_busy = 1'b0;
`ifdef IO_BRIDGE_PARITY_EN
        in_parity = 1'b0;
`endif
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_io_we", 32'(io_we), 32'(0));
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_word_cnt", 32'(word_cnt), 32'(0));
        chk("rst_data_io", data_io, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Basic word, latency two cycles after the last byte.
        send_word(32'hA1B2C3D4, 0);
        expect_write(32'hA1B2C3D4, 0, 1'b0, 1'b0);
        chk("t1_cnt", 32'(word_cnt), 32'(1));

        // Busy for 5 cycles; a held byte during PENDING/WRITE must not be consumed.
        send_word(32'hA1B2C3D4, 0);
        expect_write(32'hA1B2C3D4, 5, 1'b0, 1'b1);

        // Partial word aborted (byte presented with abort is dropped).
        send_byte(8'h11);
        send_byte(8'h22);
        in_valid = 1'b1; in_byte = 8'h99; in_abort = 1'b1;
        step();
        in_valid = 1'b0; in_abort = 1'b0;
        chk("abort_collect_ready", 32'(in_ready), 32'(1));
        q.delete();
        we_before = we_seen;
        send_word(32'h12345678, 0);
        expect_write(32'h12345678, 0, 1'b0, 1'b0);
        chk("abort_one_write", 32'(we_seen - we_before), 32'(1));

        // Abort while PENDING discards the word.
        send_word(32'hDEADBEEF, 0);
        rf_we_busy = 1'b1;
        in_abort = 1'b1;
        step();
        in_abort = 1'b0; rf_we_busy = 1'b0;
        q.delete();
        chk("pabort_pending", 32'(pending), 32'(0));
        chk("pabort_ready", 32'(in_ready), 32'(1));
        step();
        chk("pabort_we", 32'(io_we), 32'(0));
        chk("pabort_cnt", 32'(word_cnt), 32'(exp_cnt));
        chk("pabort_data", data_io, 32'h12345678);

        // Random words with gaps, busy stalls, mid-word and pending aborts.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(4, 0) == 0) begin
                int nb;
                nb = int'($urandom_range(3, 1));
                for (int k = 0; k < nb; k++) send_byte(8'($urandom));
                in_abort = 1'b1;
                step();
                in_abort = 1'b0;
                q.delete();
            end
            send_word(w, 2);
            exp_word = model_word();
            if ($urandom_range(5, 0) == 0) begin
                in_abort = 1'b1;
                step();
                in_abort = 1'b0;
                q.delete();
                chk("rnd_pabort_ready", 32'(in_ready), 32'(1));
                chk("rnd_pabort_cnt", 32'(word_cnt), 32'(exp_cnt));
            end else begin
                expect_write(exp_word, int'($urandom_range(3, 0)),
                             1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            end
        end

        // 256 back-to-back words: counter wraps, 6-cycle period.
        do_reset();
        for (int n = 0; n < 256; n++) begin
            send_word(32'h11111111, 0);
            expect_write(32'h11111111, 0, 1'b0, 1'b0);
            if (n > 0) chk("b2b_period", 32'(we_cyc_now - we_cyc_prev), 32'(6));
        end
        chk("b2b_wrap_cnt", 32'(word_cnt), 32'(0));
        chk("no_consec_we", 32'(consec), 32'(0));

        // Asynchronous reset while PENDING.
        send_word(32'h5A5AA5A5, 0);
        rf_we_busy = 1'b1;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_we", 32'(io_we), 32'(0));
        chk("areset_data", data_io, 32'h0);
        chk("areset_ready", 32'(in_ready), 32'(1));
        chk("areset_cnt", 32'(word_cnt), 32'(0));
        chk("areset_pending", 32'(pending), 32'(0));
        we_before = we_seen;
        step();
        rst_n = 1'b1;
        rf_we_busy = 1'b0;
        exp_cnt = 0;
        q.delete();
        for (int i = 0; i < 8; i++) step();
        chk("areset_no_write", 32'(we_seen - we_before), 32'(0));
        chk("areset_ready_after", 32'(in_ready), 32'(1));

`ifdef IO_BRIDGE_PARITY_EN
        // Bad-parity byte is swallowed without advancing; flag is sticky until abort.
        in_valid = 1'b1; in_byte = 8'h01; in_parity = 1'b0;
        step();
        in_valid = 1'b0;
        chk("par_err_set", 32'(parity_err), 32'(1));
        chk("par_ready", 32'(in_ready), 32'(1));
        send_word(32'hCAFEBABE, 0);
        expect_write(32'hCAFEBABE, 0, 1'b0, 1'b0);
        chk("par_err_sticky", 32'(parity_err), 32'(1));
        in_abort = 1'b1;
        step();
        in_abort = 1'b0;
        chk("par_err_clear", 32'(parity_err), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
